cp0_reg: RTL and testbench
==========================

# cp0_reg

- Coprocessor-0 register file: the write-back consumer of the MEM/WB stage's `wb_cp0_*` fields.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config, and raises the timer interrupt.
- Records exception state from the exception unit and clears it on ERET.
- Exposes a combinational read port to the EX stage, which handles `mfc0` and its own forwarding from MEM/WB.

## Interface
- `PRID_VALUE`, default 32'h004c0102: read-only PRId contents.
- `STATUS_RST`, default 32'h10000000: Status reset value (CU0=1).
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `we_i`  in  1  CP0 write enable from `wb_cp0_we`.
- `waddr_i`  in  5  write register number from `wb_cp0_waddr`.
- `wdata_i`  in  32  write data from `wb_cp0_wdata`.
- `raddr_i`  in  5  read register number from the EX stage.
- `int_i`  in  6  external hardware interrupt lines, level-sensitive.
- `exc_valid_i`  in  1  exception commit this cycle.
- `exc_code_i`  in  5  ExcCode of the committed exception.
- `exc_pc_i`  in  32  PC of the faulting instruction.
- `exc_bd_i`  in  1  faulting instruction is in a delay slot.
- `eret_i`  in  1  ERET commit this cycle.
- `data_o`  out  32  combinational read data for `raddr_i`.
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `config_o`, `prid_o`  out  32 each  direct register views.
- `timer_int_o`  out  1  timer interrupt request.

## Operation
- Register map: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId, 16 Config.
- Reads of any other address return 0; writes to any other address are ignored.
- Reset values:
  - Count = 0, Compare = 0, Cause = 0, EPC = 0, `timer_int_o` = 0.
  - Status = `STATUS_RST`.
  - Config = 32'h00008000 (BE=1).
  - PRId = `PRID_VALUE`.
- Count increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0. A write to Count loads `wdata_i` instead of incrementing that cycle.
- Compare is fully writable. Any Compare write clears `timer_int_o`.
- Timer interrupt:
  - When Compare != 0 and Count == Compare, `timer_int_o` sets.
  - It is sticky until the next Compare write or reset.
  - A Compare write in the same cycle as a match clears it; the write wins.
- Status: fully writable.
- Cause:
  - Only IP[9:8], WP[22] and IV[23] are writable; all other bits ignore writes.
  - Cause[15:10] <= `int_i` every cycle, unconditionally.
- EPC: fully writable. PRId and Config: read-only.
- Exception (`exc_valid_i`=1):
  - Cause[6:2] <= `exc_code_i`; Status.EXL (bit 1) <= 1.
  - If Status.EXL was 0: EPC <= `exc_bd_i` ? `exc_pc_i`-4 : `exc_pc_i`, and Cause.BD (bit 31) <= `exc_bd_i`.
  - If Status.EXL was already 1: EPC and BD are left unchanged.
- `eret_i`=1 with no exception: Status.EXL <= 0.
- Priority in one cycle: exception > eret > mtc0.
  - An mtc0 to Status, Cause or EPC in an exception cycle is dropped entirely.
  - An mtc0 to Count or Compare in an exception cycle still applies.
  - When `exc_valid_i` and `eret_i` are both 1, `eret_i` is ignored.
- Read port: no internal bypass. Reading a register in the cycle it is written returns the old value.

## Timing
- All writes, Count increment, exception and eret updates take effect at the rising edge. They are visible on `data_o` and the direct outputs from the next cycle.
- `timer_int_o` is registered: it asserts one cycle after the cycle in which Count == Compare.
- `data_o` has zero-cycle (combinational) latency from `raddr_i`.
- `rst` asserted mid-operation restores every register to its reset value at the next edge, overriding all other inputs.

## Configuration
- Macro: `CP0_TIMER_EN`.
- Defined: Count/Compare timer behaves as above.
- Undefined:
  - Count and Compare read 0 and ignore writes; no increment logic is built.
  - `timer_int_o` is tied to 0.
  - All other registers are unchanged.

## Test plan
- Reset then idle 10 cycles:
  - Count reads 10 at cycle 10.
  - Status = 32'h10000000, Config = 32'h00008000, PRId = 32'h004c0102.
- mtc0 Compare=20, Count=15:
  - `timer_int_o` rises 6 cycles after the Count write (Count==20 registered).
  - mtc0 Compare=0 clears it next edge.
- mtc0 Count=32'hFFFFFFFF: Count reads 0 the cycle after the next increment (wrap).
- Exception code 8, pc 32'h100, bd=1, EXL=0:
  - EPC = 32'hFC, Cause[31]=1, Cause[6:2]=8, Status.EXL=1.
  - A second exception with pc 32'h200 leaves EPC = 32'hFC.
- Same cycle: `exc_valid_i`, `eret_i`, mtc0 EPC=32'hDEAD:
  - EPC holds the exception value, EXL=1, 32'hDEAD discarded.
- mtc0 Cause=32'hFFFFFFFF with `int_i`=6'b100001: Cause reads 32'h00C08700 (IP, IV, WP set; BD stays 0).

Source files
------------

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and timer_int_o is 0.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE = 32'h004c0102,
    parameter logic [31:0] STATUS_RST = 32'h10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic        eret_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG  = 5'd16;
    localparam logic [31:0] CONFIG_VALUE = 32'h00008000;
    // IV, WP and IP[1:0] are the only software-writable Cause bits
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C00300;
    localparam int          EXL          = 1;

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q,  cause_d;
    logic [31:0] epc_q,    epc_d;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    assign wr_count   = we_i && (waddr_i == ADDR_COUNT);
    assign wr_compare = we_i && (waddr_i == ADDR_COMPARE);
    assign wr_status  = we_i && (waddr_i == ADDR_STATUS);
    assign wr_cause   = we_i && (waddr_i == ADDR_CAUSE);
    assign wr_epc     = we_i && (waddr_i == ADDR_EPC);

    // Exception beats eret, which beats mtc0 to Status/Cause/EPC.
    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (exc_valid_i) begin
            cause_d[6:2]  = exc_code_i;
            status_d[EXL] = 1'b1;
            if (!status_q[EXL]) begin
                epc_d       = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                cause_d[31] = exc_bd_i;
            end
        end else begin
            if (eret_i) begin
                status_d[EXL] = 1'b0;
            end else if (wr_status) begin
                status_d = wdata_i;
            end
            if (wr_cause) begin
                cause_d = (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
            end
            if (wr_epc) begin
                epc_d = wdata_i;
            end
        end
        cause_d[15:10] = int_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_q,   timer_d;

    always_comb begin
        count_d   = wr_count ? wdata_i : (count_q + 32'd1);
        compare_d = wr_compare ? wdata_i : compare_q;
        timer_d   = timer_q;
        // A Compare write in a match cycle still clears the request
        if (wr_compare) begin
            timer_d = 1'b0;
        end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_q;
`else
    assign count_o     = 32'd0;
    assign compare_o   = 32'd0;
    assign timer_int_o = 1'b0;
`endif

    assign status_o = status_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;
    assign config_o = CONFIG_VALUE;
    assign prid_o   = PRID_VALUE;

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            ADDR_COUNT:   data_o = count_o;
            ADDR_COMPARE: data_o = compare_o;
            ADDR_STATUS:  data_o = status_q;
            ADDR_CAUSE:   data_o = cause_q;
            ADDR_EPC:     data_o = epc_q;
            ADDR_PRID:    data_o = PRID_VALUE;
            ADDR_CONFIG:  data_o = CONFIG_VALUE;
            default:      data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios followed by randomized traffic
// checked against an address-indexed register model.
module tb_cp0_reg;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif
    localparam logic [31:0] PRID   = 32'h004c0102;
    localparam logic [31:0] STRST  = 32'h10000000;
    localparam logic [31:0] CWMASK = 32'h00C00300;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic        eret_i;
    logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .int_i(int_i), .exc_valid_i(exc_valid_i),
        .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i), .exc_bd_i(exc_bd_i),
        .eret_i(eret_i), .data_o(data_o), .count_o(count_o), .compare_o(compare_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o),
        .prid_o(prid_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: architectural registers indexed by CP0 register number
    logic [31:0] m [0:31];
    logic        mt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        case (a)
            5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16: return m[a];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m[12] = STRST;
        m[15] = PRID;
        m[16] = 32'h00008000;
        mt    = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] o [0:31];
        logic w9, w11;
        o = m;
        if (rst) begin
            model_reset();
            return;
        end
        w9  = we_i && waddr_i == 5'd9;
        w11 = we_i && waddr_i == 5'd11;
        if (TIMER) begin
            m[9] = w9 ? wdata_i : o[9] + 32'd1;
            if (w11) m[11] = wdata_i;
            if (w11) mt = 1'b0;
            else if (o[11] != 0 && o[9] == o[11]) mt = 1'b1;
        end
        if (exc_valid_i) begin
            m[13][6:2] = exc_code_i;
            m[12][1]   = 1'b1;
            if (!o[12][1]) begin
                m[14]     = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                m[13][31] = exc_bd_i;
            end
        end else begin
            if (eret_i) m[12][1] = 1'b0;
            else if (we_i && waddr_i == 5'd12) m[12] = wdata_i;
            if (we_i && waddr_i == 5'd13) m[13] = (o[13] & ~CWMASK) | (wdata_i & CWMASK);
            if (we_i && waddr_i == 5'd14) m[14] = wdata_i;
        end
        m[13][15:10] = int_i;
    endtask

    task automatic cycle();
        #1;
        check("data_o", data_o, mread(raddr_i));
        @(posedge clk);
        model_step();
        #1;
        check("count_o",   count_o,   m[9]);
        check("compare_o", compare_o, m[11]);
        check("status_o",  status_o,  m[12]);
        check("cause_o",   cause_o,   m[13]);
        check("epc_o",     epc_o,     m[14]);
        check("prid_o",    prid_o,    m[15]);
        check("config_o",  config_o,  m[16]);
        check("timer_int", {31'd0, timer_int_o}, {31'd0, mt});
        $display("cyc rst=%0b we=%0b wa=%0d wd=%08h exc=%0b eret=%0b cnt=%08h st=%08h ca=%08h epc=%08h ti=%0b",
                 rst, we_i, waddr_i, wdata_i, exc_valid_i, eret_i, count_o, status_o, cause_o, epc_o, timer_int_o);
    endtask

    task automatic idle();
        rst = 0; we_i = 0; waddr_i = 0; wdata_i = 0; int_i = 0;
        exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_bd_i = 0; eret_i = 0;
        raddr_i = 5'($urandom_range(0, 31));
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); cycle(); idle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); we_i = 1; waddr_i = a; wdata_i = d; cycle(); idle();
    endtask

    initial begin
        logic [4:0] addr_tab [0:7];
        addr_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};
        model_reset();
        do_reset();
        check("rst_status", status_o, 32'h10000000);
        check("rst_config", config_o, 32'h00008000);
        check("rst_prid",   prid_o,   32'h004c0102);
        check("rst_epc",    epc_o,    32'd0);
        for (int i = 0; i < 10; i++) cycle();
        check("count_at_10", count_o, TIMER ? 32'd10 : 32'd0);

        // Timer: Compare=20, Count=15, match registered six edges after the Count write
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd15);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("timer_early", {31'd0, timer_int_o}, 32'd0);
        end
        cycle();
        check("timer_rise", {31'd0, timer_int_o}, {31'd0, TIMER});
        mtc0(5'd11, 32'd0);
        check("timer_clear", {31'd0, timer_int_o}, 32'd0);

        mtc0(5'd9, 32'hFFFFFFFF);
        check("count_max", count_o, TIMER ? 32'hFFFFFFFF : 32'd0);
        cycle();
        check("count_wrap", count_o, 32'd0);

        // Exceptions
        do_reset();
        exc_valid_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h100; exc_bd_i = 1;
        cycle(); idle();
        check("exc_epc",   epc_o, 32'hFC);
        check("exc_cause", cause_o & 32'h8000007C, 32'h80000020);
        check("exc_exl",   {31'd0, status_o[1]}, 32'd1);
        exc_valid_i = 1; exc_code_i = 5'd4; exc_pc_i = 32'h200; exc_bd_i = 0;
        cycle(); idle();
        check("exc2_epc", epc_o, 32'hFC);
        exc_valid_i = 1; exc_code_i = 5'd8; exc_pc_i = 32'h300; eret_i = 1;
        we_i = 1; waddr_i = 5'd14; wdata_i = 32'hDEAD;
        cycle(); idle();
        check("combo_epc", epc_o, 32'hFC);
        check("combo_exl", {31'd0, status_o[1]}, 32'd1);
        eret_i = 1; cycle(); idle();
        check("eret_exl", {31'd0, status_o[1]}, 32'd0);

        do_reset();
        int_i = 6'b100001; we_i = 1; waddr_i = 5'd13; wdata_i = 32'hFFFFFFFF;
        cycle(); idle();
        check("cause_wmask", cause_o, 32'h00C08700);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst         = ($urandom_range(0, 63) == 0);
            we_i        = $urandom_range(0, 1) == 1;
            waddr_i     = ($urandom_range(0, 7) == 7) ? 5'($urandom) : addr_tab[$urandom_range(0, 6)];
            wdata_i     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            int_i       = 6'($urandom);
            exc_valid_i = ($urandom_range(0, 7) == 0);
            exc_code_i  = 5'($urandom);
            exc_pc_i    = $urandom;
            exc_bd_i    = $urandom_range(0, 1) == 1;
            eret_i      = ($urandom_range(0, 7) == 0);
            if (eret_i && waddr_i == 5'd12) we_i = 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
